// File: rtl/bsg_wormhole_link_packet_rr_mux.sv
`default_nettype none
// bsg_wormhole_link_packet_rr_mux: packet-aware round-robin merge of wormhole links.
// Define BSG_WORMHOLE_LINK_PACKET_RR_MUX_OUT_FIFO_EN to add a 2-entry registered output FIFO.
module bsg_wormhole_link_packet_rr_mux #(
  parameter int num_in_p     = 2,
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 7,
  parameter int len_width_p  = 4,
  parameter int lg_num_in_lp = $clog2(num_in_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_in_p-1:0]              in_v_i,
  input  logic [num_in_p*flit_width_p-1:0] in_data_i,
  output logic [num_in_p-1:0]              in_ready_and_o,
  output logic                             out_v_o,
  output logic [flit_width_p-1:0]          out_data_o,
  input  logic                             out_ready_and_i,
  output logic [lg_num_in_lp-1:0]          out_src_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [lg_num_in_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [lg_num_in_lp-1:0] grant_q, grant_d;
  logic [len_width_p-1:0]  cnt_q, cnt_d;

  logic [lg_num_in_lp-1:0] arb_g, sel;
  logic                    arb_v, sel_v, sink_ready, xfer;
  logic [flit_width_p-1:0] sel_data;
  logic [len_width_p-1:0]  hdr_len;

  function automatic logic [lg_num_in_lp-1:0] wrap_inc(input logic [lg_num_in_lp-1:0] x);
    if (x == lg_num_in_lp'(num_in_p - 1)) return '0;
    return x + lg_num_in_lp'(1);
  endfunction

  // Descending scan so the valid input closest to rr_ptr_q is written last and wins.
  always_comb begin
    int idx;
    idx   = 0;
    arb_v = 1'b0;
    arb_g = rr_ptr_q;
    for (int k = num_in_p - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % num_in_p;
      if (in_v_i[idx[lg_num_in_lp-1:0]]) begin
        arb_v = 1'b1;
        arb_g = idx[lg_num_in_lp-1:0];
      end
    end
  end

  always_comb begin
    sel      = (state_q == BUSY) ? grant_q : arb_g;
    sel_v    = (state_q == BUSY) ? in_v_i[grant_q] : arb_v;
    sel_data = in_data_i[int'(sel)*flit_width_p +: flit_width_p];
    hdr_len  = sel_data[cord_width_p +: len_width_p];
    xfer     = reset_n_i & sel_v & sink_ready;
  end

  always_comb begin
    in_ready_and_o = '0;
    if (reset_n_i && sink_ready) in_ready_and_o[sel] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_len == '0) begin
            rr_ptr_d = wrap_inc(arb_g);
          end else begin
            grant_d = arb_g;
            cnt_d   = hdr_len;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          cnt_d = cnt_q - len_width_p'(1);
          if (cnt_q == len_width_p'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(grant_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BSG_WORMHOLE_LINK_PACKET_RR_MUX_OUT_FIFO_EN
  logic [lg_num_in_lp+flit_width_p-1:0] fifo_mem_q [2];
  logic [lg_num_in_lp+flit_width_p-1:0] fifo_mem_d [2];
  logic [1:0] fifo_cnt_q, fifo_cnt_d;
  logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic       not_full_q, not_full_d;
  logic       deq;

  // Accepting only on the registered not-full cuts the out_ready -> in_ready path.
  always_comb begin
    sink_ready = not_full_q;
    out_v_o    = (fifo_cnt_q != 2'd0);
    {out_src_o, out_data_o} = fifo_mem_q[rd_ptr_q];
    deq        = out_v_o & out_ready_and_i;
    fifo_mem_d = fifo_mem_q;
    if (xfer) fifo_mem_d[wr_ptr_q] = {sel, sel_data};
    wr_ptr_d   = wr_ptr_q ^ xfer;
    rd_ptr_d   = rd_ptr_q ^ deq;
    fifo_cnt_d = fifo_cnt_q + {1'b0, xfer} - {1'b0, deq};
    not_full_d = (fifo_cnt_d != 2'd2);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      not_full_q    <= 1'b1;
    end else begin
      fifo_mem_q    <= fifo_mem_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      not_full_q    <= not_full_d;
    end
  end
`else
  // Pass-through outputs are forced to their reset values while reset is asserted.
  always_comb begin
    sink_ready = out_ready_and_i;
    out_v_o    = reset_n_i & sel_v;
    out_data_o = reset_n_i ? sel_data : '0;
    out_src_o  = reset_n_i ? sel : '0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_wormhole_link_packet_rr_mux.sv
`default_nettype none
// Bench for bsg_wormhole_link_packet_rr_mux: directed phases plus randomized traffic
// scored against a packet-level round-robin model and an in-order flit scoreboard.
module tb_bsg_wormhole_link_packet_rr_mux;
  localparam int N4 = 4;
  localparam int N3 = 3;
  localparam int FW = 32;
  localparam int CW = 7;
  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, rst3_n;
  logic [N4-1:0]    v4, rdy4;
  logic [N4*FW-1:0] data4;
  logic             ov4, ordy4;
  logic [FW-1:0]    od4;
  logic [1:0]       osrc4;
  logic [N3-1:0]    v3, rdy3;
  logic [N3*FW-1:0] data3;
  logic             ov3, ordy3;
  logic [FW-1:0]    od3;
  logic [1:0]       osrc3;

  bsg_wormhole_link_packet_rr_mux #(
    .num_in_p(N4), .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW)
  ) u_dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .in_v_i(v4), .in_data_i(data4),
    .in_ready_and_o(rdy4), .out_v_o(ov4), .out_data_o(od4),
    .out_ready_and_i(ordy4), .out_src_o(osrc4)
  );

  bsg_wormhole_link_packet_rr_mux #(
    .num_in_p(N3), .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW)
  ) u_dut3 (
    .clk_i(clk), .reset_n_i(rst3_n), .in_v_i(v3), .in_data_i(data3),
    .in_ready_and_o(rdy3), .out_v_o(ov3), .out_data_o(od3),
    .out_ready_and_i(ordy3), .out_src_o(osrc3)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [FW-1:0] tx4 [N4][256];
  int            tx4_len [N4];
  int            tx4_pos [N4];
  bit            hold4   [N4];
  logic [FW-1:0] tx3 [N3][32];
  int            tx3_len [N3];
  int            tx3_pos [N3];
  bit            gate3;
  bit            rnd_rdy;

  int         m_owner, m_rem, m_ptr;
  logic [33:0] exp_q[$];
  logic [1:0]  got_src4[$];
  logic [33:0] got3[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_hdr(input int len);
    logic [FW-1:0] h;
    h = $urandom;
    h[CW +: LW] = len[LW-1:0];
    return h;
  endfunction

  task automatic add_pkt4(input int i, input int len);
    tx4[i][tx4_len[i]] = mk_hdr(len);
    for (int b = 1; b <= len; b++) tx4[i][tx4_len[i] + b] = $urandom;
    tx4_len[i] += len + 1;
  endtask

  task automatic add_pkt3(input int i, input int len);
    tx3[i][tx3_len[i]] = mk_hdr(len);
    for (int b = 1; b <= len; b++) tx3[i][tx3_len[i] + b] = $urandom;
    tx3_len[i] += len + 1;
  endtask

  task automatic clear4();
    for (int i = 0; i < N4; i++) begin
      tx4_len[i] = 0; tx4_pos[i] = 0; hold4[i] = 1'b0;
    end
  endtask

  task automatic clear3();
    for (int i = 0; i < N3; i++) begin
      tx3_len[i] = 0; tx3_pos[i] = 0;
    end
  endtask

  function automatic bit idle4();
    for (int i = 0; i < N4; i++) if (tx4_pos[i] < tx4_len[i]) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  // Packet-level arbitration rules: locked owner, else first valid from the pointer.
  task automatic check4();
    int          eg, acc, nacc, len, idx;
    logic [FW-1:0] flit;
    logic [33:0] e;
    eg = -1;
    if (m_owner >= 0) eg = m_owner;
    else begin
      for (int k = 0; k < N4; k++) begin
        idx = (m_ptr + k) % N4;
        if (eg < 0 && v4[idx[1:0]]) eg = idx;
      end
    end
    acc = -1; nacc = 0;
    for (int i = 0; i < N4; i++) if (v4[i] && rdy4[i]) begin acc = i; nacc++; end
    if (nacc > 0) begin
      chk("accept_count", nacc, 1);
      chk("grant", acc, eg);
      flit = tx4[acc][tx4_pos[acc]];
      tx4_pos[acc]++;
      exp_q.push_back({acc[1:0], flit});
      if (m_owner < 0) begin
        len = int'(flit[CW +: LW]);
        if (len == 0) m_ptr = (acc + 1) % N4;
        else begin m_owner = acc; m_rem = len; end
      end else begin
        m_rem--;
        if (m_rem == 0) begin m_owner = -1; m_ptr = (acc + 1) % N4; end
      end
    end
    if (ov4 && ordy4) begin
      got_src4.push_back(osrc4);
      chk("out_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_src", osrc4, e[33:32]);
        chk("out_data", od4, e[31:0]);
      end
    end
  endtask

  task automatic check3();
    for (int i = 0; i < N3; i++) if (v3[i] && rdy3[i]) tx3_pos[i]++;
    if (ov3 && ordy3) got3.push_back({osrc3, od3});
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N4; i++) begin
      v4[i] = (tx4_pos[i] < tx4_len[i]) && !hold4[i];
      data4[i*FW +: FW] = (tx4_pos[i] < tx4_len[i]) ? tx4[i][tx4_pos[i]] : '0;
    end
    for (int i = 0; i < N3; i++) begin
      v3[i] = (tx3_pos[i] < tx3_len[i]) && (i == 2 || gate3);
      data3[i*FW +: FW] = (tx3_pos[i] < tx3_len[i]) ? tx3[i][tx3_pos[i]] : '0;
    end
    ordy4 = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (rst_n) check4();
    if (rst3_n) check3();
  endtask

  task automatic drain4(input string tag, input int limit);
    int c;
    c = 0;
    while (!idle4() && c < limit) begin tick(); c++; end
    chk(tag, idle4(), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, start, nz, expv;
    logic [33:0] g;
    rst_n = 1'b0; rst3_n = 1'b0;
    v4 = '0; data4 = '0; ordy4 = 1'b1;
    v3 = '0; data3 = '0; ordy3 = 1'b1;
    gate3 = 1'b0; rnd_rdy = 1'b0;
    clear4(); clear3();
    m_owner = -1; m_rem = 0; m_ptr = 0;

    // Reset held with every input valid
    add_pkt4(0, 1); add_pkt4(1, 0); add_pkt4(2, 2); add_pkt4(3, 0);
    repeat (3) tick();
    chk("rst_out_v", ov4, 0);
    chk("rst_ready", rdy4, 0);
    chk("rst_src", osrc4, 0);
    chk("rst_data", od4, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    got_src4.delete();
    drain4("p0_drain", 50);
    chk("first_src", (got_src4.size() > 0) ? got_src4[0] : 2'd3, 0);

    // Back-to-back len==0 headers rotate one per cycle
    clear4(); got_src4.delete(); start = m_ptr;
    for (int i = 0; i < N4; i++) repeat (3) add_pkt4(i, 0);
    repeat (12) tick();
    chk("rr_rate", got_src4.size() >= 11, 1);
    drain4("p1_drain", 20);
    chk("rr_count", got_src4.size(), 12);
    for (int k = 0; k < got_src4.size(); k++) chk("rr_order", got_src4[k], (start + k) % N4);

    // No interleave: input 1 appears while input 0 owns the link
    clear4(); got_src4.delete();
    add_pkt4(0, 3); add_pkt4(1, 0); hold4[1] = 1'b1;
    tick(); hold4[1] = 1'b0;
    drain4("p2_drain", 30);
    chk("ni_count", got_src4.size(), 5);
    for (int k = 0; k < got_src4.size(); k++) chk("ni_order", got_src4[k], (k < 4) ? 0 : 1);

    // Stall: random out_ready and a 5-cycle valid gap inside a 16-flit packet
    clear4(); got_src4.delete();
    add_pkt4(0, 15); add_pkt4(1, 2); add_pkt4(2, 2);
    hold4[1] = 1'b1; hold4[2] = 1'b1;
    repeat (2) tick();
    hold4[1] = 1'b0; hold4[2] = 1'b0; rnd_rdy = 1'b1;
    c = 0;
    while (tx4_pos[0] < 4 && c < 100) begin tick(); c++; end
    hold4[0] = 1'b1;
    repeat (5) tick();
    hold4[0] = 1'b0;
    drain4("p3_drain", 300);
    chk("stall_count", got_src4.size(), 22);
    nz = 0;
    for (int k = 0; k < 16 && k < got_src4.size(); k++) if (got_src4[k] != 2'd0) nz++;
    chk("stall_contig", nz, 0);

    // Randomized traffic on all inputs
    clear4();
    for (int i = 0; i < N4; i++) repeat (6) add_pkt4(i, $urandom_range(0, 15));
    c = 0;
    while (!idle4() && c < 3000) begin
      for (int i = 0; i < N4; i++) hold4[i] = ($urandom_range(0, 4) == 0);
      tick(); c++;
    end
    for (int i = 0; i < N4; i++) hold4[i] = 1'b0;
    chk("rand_done", idle4(), 1);
    rnd_rdy = 1'b0;

    // Asynchronous reset after 2 of 5 flits
    clear4(); got_src4.delete();
    add_pkt4(0, 4);
    c = 0;
    while (got_src4.size() < 2 && c < 20) begin tick(); c++; end
    chk("ar_pre", got_src4.size(), 2);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("ar_out_v", ov4, 0);
    chk("ar_ready", rdy4, 0);
    chk("ar_src", osrc4, 0);
    chk("ar_data", od4, 0);
    m_owner = -1; m_rem = 0; m_ptr = 0; exp_q.delete(); clear4();
    repeat (2) tick();
    @(posedge clk); #2 rst_n = 1'b1;
    got_src4.delete();
    add_pkt4(0, 0); add_pkt4(1, 1);
    drain4("ar_drain", 30);
    chk("ar_count", got_src4.size(), 3);
    for (int k = 0; k < got_src4.size(); k++) chk("ar_order", got_src4[k], (k == 0) ? 0 : 1);

    // Three inputs: max-length packet from input 2, pointer wraps to 0
    clear3(); got3.delete(); gate3 = 1'b0;
    add_pkt3(2, 15); add_pkt3(0, 0); add_pkt3(1, 0);
    @(posedge clk); #2 rst3_n = 1'b1;
    tick(); gate3 = 1'b1;
    c = 0;
    while (got3.size() < 18 && c < 100) begin tick(); c++; end
    chk("wrap_count", got3.size(), 18);
    for (int k = 0; k < got3.size(); k++) begin
      g = got3[k];
      expv = (k < 16) ? 2 : ((k == 16) ? 0 : 1);
      chk("wrap_src", g[33:32], expv);
      chk("wrap_data", g[31:0], (k < 16) ? tx3[2][k] : tx3[expv][0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
